pipe_cfg_ctrl: RTL and testbench

PIPE_CFG_CTRL -- requirements
Module: pipe_cfg_ctrl

---
 rtl/video_pkg.sv | 18 +
 rtl/pipe_cfg_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_cfg_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video-pipe types: controller state encoding and cfg bit positions.
package video_pkg;

  typedef enum logic [1:0] {
    ST_TPG   = 2'd0,
    ST_ARM   = 2'd1,
    ST_CAM   = 2'd2,
    ST_FAULT = 2'd3
  } pipe_ctrl_state_t;

  localparam int CFG_SRC    = 0;
  localparam int CFG_GREY   = 1;
  localparam int CFG_709    = 2;
  localparam int CFG_INV    = 3;
  localparam int CFG_BORDER = 4;
  localparam int CFG_W      = 5;

endpackage

// File: rtl/pipe_cfg_ctrl.sv
// Frame-synchronous pipeline configuration: requests apply only at vs_start_i,
// camera source is granted after readiness, with timeout and error fallback to TPG.
module pipe_cfg_ctrl
  import video_pkg::*;
#(
  parameter int N_TIMEOUT_FR = 4,
  parameter int FR_CNT_W     = 8
) (
  input  logic                clk_pix,
  input  logic                rst_i,
  input  logic                vs_start_i,
  input  logic [CFG_W-1:0]    req_i,
  input  logic                cam_rdy_i,
  input  logic                cam_err_i,
  output logic [CFG_W-1:0]    cfg_o,
  output logic                cfg_upd_o,
  output logic                cam_fb_o,
  output logic [1:0]          state_o,
  output logic [FR_CNT_W-1:0] frame_cnt_o
);

  localparam logic [7:0] TMO_LIM = 8'(N_TIMEOUT_FR);

  pipe_ctrl_state_t    state_q, state_d;
  logic [7:0]          tmo_q, tmo_d, tmo_inc;
  logic                err_pend_q, err_pend_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                upd_q, upd_d;
  logic [FR_CNT_W-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk_pix or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_TPG;
      tmo_q      <= '0;
      err_pend_q <= 1'b0;
      cfg_q      <= '0;
      upd_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      err_pend_q <= err_pend_d;
      cfg_q      <= cfg_d;
      upd_q      <= upd_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tmo_inc    = tmo_q + 8'd1;
    err_pend_d = err_pend_q;
    cfg_d      = cfg_q;
    upd_d      = 1'b0;
    fcnt_d     = fcnt_q;

    // Errors are remembered for the whole frame and acted on at the boundary.
    if (state_q == ST_CAM && cam_err_i) err_pend_d = 1'b1;

    if (vs_start_i) begin
      fcnt_d = fcnt_q + FR_CNT_W'(1);
      case (state_q)
        ST_TPG: begin
          if (req_i[CFG_SRC]) begin
            state_d = ST_ARM;
            tmo_d   = '0;
          end
        end
        ST_ARM: begin
          if (!req_i[CFG_SRC]) begin
            state_d = ST_TPG;
          end else if (cam_rdy_i) begin
            state_d = ST_CAM;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_LIM) state_d = ST_FAULT;
          end
        end
        ST_CAM: begin
          // Fault wins over a voluntary return so the fallback flag is never lost.
          if (err_pend_q || cam_err_i || !cam_rdy_i) begin
            state_d = ST_FAULT;
          end else if (!req_i[CFG_SRC]) begin
            state_d = ST_TPG;
          end
        end
        ST_FAULT: begin
          if (!req_i[CFG_SRC]) state_d = ST_TPG;
        end
        default: state_d = ST_TPG;
      endcase

      if (state_d != ST_CAM) err_pend_d = 1'b0;

      cfg_d[CFG_BORDER:CFG_GREY] = req_i[CFG_BORDER:CFG_GREY];
      cfg_d[CFG_SRC]             = (state_d == ST_CAM);
      upd_d                      = (cfg_d != cfg_q);
    end
  end

  assign cfg_o       = cfg_q;
  assign cfg_upd_o   = upd_q;
  assign cam_fb_o    = (state_q == ST_FAULT);
  assign state_o     = state_q;
  assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_pipe_cfg_ctrl.sv
// Directed bench for pipe_cfg_ctrl with a boundary-level reference model and
// an expected-result queue checked one cycle after each vs_start_i.
module tb_pipe_cfg_ctrl;
  import video_pkg::*;

  localparam int N = 4;

  logic       clk_pix = 1'b0;
  logic       rst_i;
  logic       vs_start_i;
  logic [4:0] req_i;
  logic       cam_rdy_i;
  logic       cam_err_i;
  logic [4:0] cfg_o;
  logic       cfg_upd_o;
  logic       cam_fb_o;
  logic [1:0] state_o;
  logic [7:0] frame_cnt_o;

  pipe_cfg_ctrl #(.N_TIMEOUT_FR(N), .FR_CNT_W(8)) dut (
    .clk_pix     (clk_pix),
    .rst_i       (rst_i),
    .vs_start_i  (vs_start_i),
    .req_i       (req_i),
    .cam_rdy_i   (cam_rdy_i),
    .cam_err_i   (cam_err_i),
    .cfg_o       (cfg_o),
    .cfg_upd_o   (cfg_upd_o),
    .cam_fb_o    (cam_fb_o),
    .state_o     (state_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [4:0] cfg;
    logic       upd;
    logic       fb;
    logic [1:0] st;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int upd_seen = 0;

  pipe_ctrl_state_t m_st;
  int               m_tmo;
  logic             m_pend;
  logic [4:0]       m_cfg;
  logic [7:0]       m_fc;

  always @(negedge clk_pix) if (cfg_upd_o === 1'b1) upd_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_TPG; m_tmo = 0; m_pend = 1'b0; m_cfg = '0; m_fc = '0;
  endtask

  task automatic cycle();
    @(posedge clk_pix);
    #1;
  endtask

  // Apply one frame boundary to the model and queue the result the DUT must show next cycle.
  task automatic model_vs(input logic [4:0] r, input logic rdy, input logic err);
    pipe_ctrl_state_t ns;
    exp_t e;
    ns = m_st;
    case (m_st)
      ST_TPG:   if (r[0]) begin ns = ST_ARM; m_tmo = 0; end
      ST_ARM: begin
        if (!r[0]) ns = ST_TPG;
        else if (rdy) ns = ST_CAM;
        else begin
          m_tmo++;
          if (m_tmo == N) ns = ST_FAULT;
        end
      end
      ST_CAM: begin
        if (m_pend || err || !rdy) ns = ST_FAULT;
        else if (!r[0]) ns = ST_TPG;
      end
      default:  if (!r[0]) ns = ST_TPG;
    endcase
    if (ns != ST_CAM) m_pend = 1'b0;
    e.cfg = {r[4:1], ns == ST_CAM};
    e.upd = (e.cfg != m_cfg);
    e.fb  = (ns == ST_FAULT);
    e.st  = ns;
    m_fc  = m_fc + 8'd1;
    e.fc  = m_fc;
    m_cfg = e.cfg;
    m_st  = ns;
    sb.push_back(e);
  endtask

  task automatic boundary(input logic [4:0] r, input logic rdy, input logic err);
    exp_t e;
    vs_start_i = 1'b1; req_i = r; cam_rdy_i = rdy; cam_err_i = err;
    model_vs(r, rdy, err);
    cycle();
    vs_start_i = 1'b0; cam_err_i = 1'b0;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bnd_cfg", 32'(cfg_o), 32'(e.cfg));
      chk("bnd_upd", 32'(cfg_upd_o), 32'(e.upd));
      chk("bnd_fb", 32'(cam_fb_o), 32'(e.fb));
      chk("bnd_state", 32'(state_o), 32'(e.st));
      chk("bnd_fcnt", 32'(frame_cnt_o), 32'(e.fc));
    end
  endtask

  task automatic idle(input int n, input logic [4:0] r, input logic rdy);
    for (int i = 0; i < n; i++) begin
      req_i = r; cam_rdy_i = rdy;
      cycle();
      chk("idle_cfg", 32'(cfg_o), 32'(m_cfg));
      chk("idle_upd", 32'(cfg_upd_o), 32'd0);
      chk("idle_state", 32'(state_o), 32'(m_st));
    end
  endtask

  task automatic err_pulse();
    cam_err_i = 1'b1;
    if (m_st == ST_CAM) m_pend = 1'b1;
    cycle();
    cam_err_i = 1'b0;
    chk("err_cfg", 32'(cfg_o), 32'(m_cfg));
    chk("err_state", 32'(state_o), 32'(m_st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    rst_i = 1'b1; vs_start_i = 1'b0; req_i = '0; cam_rdy_i = 1'b0; cam_err_i = 1'b0;
    model_reset();
    cycle(); cycle();
    chk("rst_cfg", 32'(cfg_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt_o), 32'd0);
    rst_i = 1'b0;
    idle(2, 5'b00000, 1'b0);

    // Grey request held over three frames: one update, source stays TPG.
    upd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      boundary(5'b00010, 1'b0, 1'b0);
      idle(3, 5'b00010, 1'b0);
    end
    chk("grey_upd_count", 32'(upd_seen), 32'd1);
    chk("grey_cfg", 32'(cfg_o), 32'h02);
    chk("grey_state", 32'(state_o), 32'd0);

    // Mid-frame toggles restored before the boundary are invisible.
    u0 = upd_seen;
    idle(2, 5'b11110, 1'b1);
    idle(2, 5'b00010, 1'b0);
    boundary(5'b00010, 1'b0, 1'b0);
    idle(2, 5'b00010, 1'b0);
    chk("glitch_upd_count", 32'(upd_seen), 32'(u0));

    // TPG -> ARM -> CAM.
    boundary(5'b00011, 1'b0, 1'b0);
    chk("arm_state", 32'(state_o), 32'd1);
    idle(2, 5'b00011, 1'b1);
    boundary(5'b00011, 1'b1, 1'b0);
    chk("cam_state", 32'(state_o), 32'd2);
    chk("cam_src", 32'(cfg_o[0]), 32'd1);

    // Mid-frame error holds source until the boundary, then FAULT.
    idle(2, 5'b00011, 1'b1);
    err_pulse();
    idle(3, 5'b00011, 1'b1);
    chk("err_hold_src", 32'(cfg_o[0]), 32'd1);
    boundary(5'b00011, 1'b1, 1'b0);
    chk("err_fault_state", 32'(state_o), 32'd3);
    chk("err_fault_src", 32'(cfg_o[0]), 32'd0);
    chk("err_fault_fb", 32'(cam_fb_o), 32'd1);
    boundary(5'b10101, 1'b1, 1'b0);
    boundary(5'b00000, 1'b1, 1'b0);
    chk("fault_exit_fb", 32'(cam_fb_o), 32'd0);

    // Readiness timeout: FAULT exactly at boundary 5.
    for (int i = 1; i <= 5; i++) begin
      boundary(5'b01001, 1'b0, 1'b0);
      if (i == 4) chk("tmo_arm_b4", 32'(state_o), 32'd1);
      idle(1, 5'b01001, 1'b0);
    end
    chk("tmo_fault_state", 32'(state_o), 32'd3);
    chk("tmo_fault_fb", 32'(cam_fb_o), 32'd1);

    // Error at the boundary beats a release request.
    boundary(5'b00000, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00000, 1'b1, 1'b1);
    chk("coinc_err_state", 32'(state_o), 32'd3);
    // Readiness loss, voluntary exits from CAM and ARM.
    boundary(5'b00000, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00001, 1'b0, 1'b0);
    chk("rdy_loss_state", 32'(state_o), 32'd3);
    boundary(5'b00000, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00001, 1'b1, 1'b0);
    boundary(5'b00000, 1'b1, 1'b0);
    chk("cam_exit_state", 32'(state_o), 32'd0);
    boundary(5'b00001, 1'b0, 1'b0);
    boundary(5'b00000, 1'b0, 1'b0);
    chk("arm_exit_state", 32'(state_o), 32'd0);

    // Asynchronous reset from CAM.
    boundary(5'b11111, 1'b1, 1'b0);
    boundary(5'b11111, 1'b1, 1'b0);
    chk("pre_rst_state", 32'(state_o), 32'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_cfg", 32'(cfg_o), 32'd0);
    chk("arst_upd", 32'(cfg_upd_o), 32'd0);
    chk("arst_fb", 32'(cam_fb_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt_o), 32'd0);
    model_reset();
    cycle(); cycle();
    rst_i = 1'b0;
    idle(3, 5'b00001, 1'b1);
    for (int i = 0; i < 260; i++) boundary(5'b00000, 1'b0, 1'b0);
    chk("fcnt_wrap", 32'(frame_cnt_o), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
